// File: rtl/mdu_hilo.sv
// Purpose : multiply/divide unit that owns the HI/LO registers (mult, multu, div, divu, mthi, mtlo).
// Latency : mult/multu hold busy for MULT_CYCLES and div/divu for DIV_CYCLES; mthi/mtlo write at the start edge.
// Backpressure: while busy is high every start is dropped; the caller must stall on busy, nothing is queued.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-low; clears HI/LO and discards any in-flight op
//   start  - request strobe, sampled on the rising edge
//   op     - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
//   A, B   - operands (rs / rt values)
//   busy   - high while a mult/div is in flight; decoded from the cycle counter only
//   HI, LO - architectural HI/LO registers (direct register outputs)
//
// MULT_CYCLES and DIV_CYCLES must both be at least 1.

module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  // Counter is sized for the longer of the two operation latencies.
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  // Cleared for a divide by zero so the final edge leaves HI/LO untouched.
  logic             pend_ok_q, pend_ok_d;

  // ---------------------------------------------------------------------------
  // Arithmetic. The result is computed from the operands present at the start
  // edge and parked in the pending registers; the cycle counter only models
  // the latency seen by the rest of the pipeline.
  // ---------------------------------------------------------------------------
  logic [63:0] a_sext, b_sext;
  logic [63:0] a_zext, b_zext;
  logic [63:0] prod_s, prod_u;

  assign a_sext = {{32{A[31]}}, A};
  assign b_sext = {{32{B[31]}}, B};
  assign a_zext = {32'd0, A};
  assign b_zext = {32'd0, B};
  assign prod_s = a_sext * b_sext;   // low 64 bits of the sign-extended product are exact
  assign prod_u = a_zext * b_zext;

  // Signed divide is done on magnitudes and the signs are reapplied. This keeps
  // 0x80000000 / 0xFFFFFFFF well defined: |A| = 0x80000000, |B| = 1, both
  // negative, so the quotient stays 0x80000000 with remainder 0.
  logic        div_signed;
  logic [31:0] mag_a, mag_b;
  logic [31:0] div_n, div_d;
  logic [31:0] uq, ur;
  logic [31:0] div_q, div_r;
  logic        b_zero;

  assign div_signed = (op == OP_DIV);
  assign b_zero     = (B == 32'd0);
  assign mag_a      = A[31] ? (~A + 32'd1) : A;
  assign mag_b      = B[31] ? (~B + 32'd1) : B;
  assign div_n      = div_signed ? mag_a : A;
  // A zero divisor is replaced by 1 just to keep the divider defined; the
  // result is never committed in that case.
  assign div_d      = b_zero ? 32'd1 : (div_signed ? mag_b : B);
  assign uq         = div_n / div_d;
  assign ur         = div_n % div_d;

  always_comb begin
    div_q = uq;
    div_r = ur;
    if (div_signed) begin
      // Quotient truncates toward zero; remainder follows the dividend's sign.
      if (A[31] ^ B[31]) div_q = ~uq + 32'd1;
      if (A[31])         div_r = ~ur + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_ok_d = pend_ok_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              pend_hi_d = prod_s[63:32];
              pend_lo_d = prod_s[31:0];
              pend_ok_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = BUSY;
            end
            OP_MULTU: begin
              pend_hi_d = prod_u[63:32];
              pend_lo_d = prod_u[31:0];
              pend_ok_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = BUSY;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = div_r;
              pend_lo_d = div_q;
              pend_ok_d = ~b_zero;
              cnt_d     = DIV_LOAD;
              state_d   = BUSY;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;  // 6/7 are no-ops
          endcase
        end
      end

      BUSY: begin
        // start is ignored here, including on the final edge.
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          if (pend_ok_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_ok_q <= pend_ok_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Purpose : directed scoreboard bench for mdu_hilo.
// Latency : expects busy for exactly MULT_CYCLES / DIV_CYCLES negedge samples per op.
// Backpressure: stimulus waits (bounded) for busy to drop before issuing the next op.

module tb_mdu_hilo;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // len == 0 : immediate probe (busy must be low); len > 0 : busy run length.
  typedef struct {
    string       name;
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];

  logic probe;
  logic done;
  int   checks;
  int   failures;

  // ---------------------------------------------------------------------------
  // Monitor: pops an expectation whenever busy falls or a probe is raised.
  // ---------------------------------------------------------------------------
  logic prev_busy;
  int   run_len;
  bit   finished;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic compare_event(input int observed_len);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: actual=output_event required=no_event");
    end else begin
      e = exp_q.pop_front();
      check_int({e.name, "_busy_len"}, observed_len, e.len);
      check32({e.name, "_hi"}, HI, e.hi);
      check32({e.name, "_lo"}, LO, e.lo);
    end
  endtask

  initial begin
    prev_busy = 1'b0;
    run_len   = 0;
    finished  = 1'b0;
    checks    = 0;
    failures  = 0;
  end

  always @(negedge clk) begin
    if (busy === 1'b1) begin
      run_len++;
      if (run_len == 40) begin
        checks++;
        failures++;
        $display("FAIL busy_timeout: actual=busy_for_%0d_cycles required=at_most_10", run_len);
      end
    end else begin
      if (prev_busy === 1'b1) compare_event(run_len);
      run_len = 0;
    end
    if (probe === 1'b1) compare_event(busy === 1'b1 ? -1 : 0);
    prev_busy = busy;

    if (done === 1'b1 && !finished) begin
      finished = 1'b1;
      check_int("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic push(input string nm, input int len, input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.name = nm;
    e.len  = len;
    e.hi   = h;
    e.lo   = l;
    exp_q.push_back(e);
  endtask

  task automatic probe_check(input string nm, input logic [31:0] h, input logic [31:0] l);
    push(nm, 0, h, l);
    probe = 1'b1;
    @(posedge clk);
    #1 probe = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    @(posedge clk);
    #1;
  endtask

  // Issues a long op, then scrambles A/B to confirm operands are sampled once.
  task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int len,
                       input logic [31:0] h, input logic [31:0] l);
    push(nm, len, h, l);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = 32'hA5A5_5A5A;
    B     = 32'h0000_0001;
    wait_idle();
  endtask

  task automatic move_to(input logic [2:0] o, input logic [31:0] a);
    start = 1'b1;
    op    = o;
    A     = a;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    A     = 32'd0;
    B     = 32'd0;
    probe = 1'b0;
    done  = 1'b0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    probe_check("reset", 32'h0, 32'h0);

    issue("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 5,  32'h0000_0002, 32'hFFFF_FFFA);
    issue("div",   3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
    issue("divu",  3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    // op 6 is a no-op: nothing changes and busy stays low.
    move_to(3'd6, 32'hDEAD_BEEF);
    probe_check("nop", 32'd2, 32'd14);

    move_to(3'd4, 32'h1111_1111);
    probe_check("mthi", 32'h1111_1111, 32'd14);
    move_to(3'd5, 32'h2222_2222);
    probe_check("mtlo", 32'h1111_1111, 32'h2222_2222);

    // divu by zero with start held through the whole busy window, including the
    // edge where busy falls: mult then mtlo requests must all be dropped.
    push("divu_zero", 10, 32'h1111_1111, 32'h2222_2222);
    start = 1'b1;
    op    = 3'd3;
    A     = 32'd7;
    B     = 32'd0;
    @(posedge clk);
    #1;
    op = 3'd0;
    A  = 32'd5;
    B  = 32'd5;
    repeat (4) @(posedge clk);
    #1;
    op = 3'd5;
    A  = 32'h3333_3333;
    repeat (6) @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    probe_check("after_div0", 32'h1111_1111, 32'h2222_2222);

    // Reset during the third busy cycle of a mult: busy drops after 3 cycles,
    // HI/LO clear, and the pending product 6 never lands.
    push("reset_mid", 3, 32'h0, 32'h0);
    start = 1'b1;
    op    = 3'd0;
    A     = 32'd2;
    B     = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    probe_check("no_late_commit", 32'h0, 32'h0);

    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=no_finish required=finish_before_200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit with HI/LO registers, sitting downstream of the GRF read ports in the datapath.
- Takes rs/rt operand values (GRF RD1/RD2) plus an op code, runs a multi-cycle mult/div, and commits results to HI/LO.
- Reports a busy flag so control can stall dependent instructions.
- HI/LO values are later returned to the GRF write path by mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, cycles busy is held for mult/multu (must be >= 1).
- DIV_CYCLES, 10, cycles busy is held for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge clears state.
- start  input  1  request; sampled on the rising edge.
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op.
- A  input  32  operand (rs value, GRF RD1).
- B  input  32  operand (rt value, GRF RD2).
- busy  output  1  high while a mult/div is in flight.
- HI  output  32  HI register (direct register output).
- LO  output  32  LO register (direct register output).

Behaviour:
- Reset:
  - When reset==0 at a clock edge: HI=0, LO=0, busy=0, counter=0, state=IDLE.
  - Any in-flight operation is discarded with no commit.
  - Reset has priority over start.
- States:
  - IDLE (counter==0, busy=0) and BUSY (counter!=0, busy=1).
  - busy is a pure decode of the counter, with no combinational path from start.
- IDLE, start=1, op=mult/multu/div/divu:
  - Latch the computed result into internal pending-HI/pending-LO.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY.
- IDLE, start=1, op=mthi/mtlo:
  - HI<=A or LO<=A at that edge, single cycle.
  - busy stays 0 and the other register is unchanged.
- IDLE, start=1, op=6/7: no effect.
- BUSY:
  - Counter decrements each edge.
  - At the edge where counter==1: HI/LO<=pending values, counter->0, state->IDLE.
  - Result: busy is high for exactly N cycles after the start edge, and new HI/LO become visible in the same cycle busy falls.
  - start in BUSY, any op including mthi/mtlo, is ignored: no queueing and no effect on pending values.
  - A start on the same edge busy falls (counter==1) is also ignored; a new op is accepted only when busy==0 before the edge.
- Arithmetic:
  - mult: signed 32x32->64, HI=product[63:32], LO=product[31:0].
  - multu: same, unsigned.
  - div: signed, quotient truncated toward zero; LO=quotient, HI=remainder, remainder takes the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000, no trap.
  - divu: unsigned.
- Divide by zero (B==0):
  - The unit still goes BUSY for DIV_CYCLES.
  - Commit is suppressed, so HI/LO keep their prior values.
- Operands are sampled only at the start edge; later changes to A/B have no effect.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> HI=0, LO=0, busy=0.
- mult A=0xFFFFFFFE, B=3 (start 1 cycle):
  - busy=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFE, B=3 -> after 5 cycles HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2:
  - busy for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero and ignored starts:
  - Preload mthi A=0x11111111, mtlo A=0x22222222.
  - Run divu A=7, B=0 -> busy 10 cycles, HI/LO unchanged.
  - Assert start with mult/mtlo during busy -> ignored, values unchanged.
- Reset mid-operation:
  - Start mult A=2, B=3.
  - Pull reset=0 on cycle 3 of busy -> busy=0, HI=0, LO=0, and no late commit of 6 afterwards.
